// File: rtl/gpu_instruction_buffer.sv
// Purpose: captures processor instruction pairs on wrreg rising edges, queues them, presents non-NOPs to the render pipeline.
// Latency: 2 cycles from the sampled wrreg rise to instr_valid when the queue and output stage are empty.
// Backpressure: instr_ready low holds the output stage; wrfull high makes new strobes drop (no retry).
//
// Ports:
//   clk_clk, reset_reset_n      - single clock domain, async active-low reset
//   wrreg, data_a, data_b       - processor write strobe (edge-detected) and 64-bit instruction pair
//   wrfull                      - registered full flag back to the processor
//   instr_valid/ready/opcode/a/b- valid/ready output stage towards the pipeline
//   frame_end, reset_pulsecounter, screen - frame divider and sticky frame-tick status
module gpu_instruction_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int FRAME_DIV  = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        wrreg,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic        wrfull,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [3:0]  instr_opcode,
    output logic [31:0] instr_a,
    output logic [31:0] instr_b,
    input  logic        frame_end,
    input  logic        reset_pulsecounter,
    output logic        screen
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);
    localparam logic [7:0]          DIV      = 8'(FRAME_DIV);

    logic [63:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  wrreg_q;
    logic                  push;
    logic                  pop;
    logic [63:0]           head;

    logic                  rpc_q;
    logic                  rpc_rise;
    logic [7:0]            frame_cnt;

    // Push decision uses the registered wrfull, so a pop in the same cycle
    // cannot free a slot for a strobe that arrives while full.
    always_comb begin
        push      = wrreg & ~wrreg_q & ~wrfull;
        // A stage holding a NOP has instr_valid=0 and is therefore reloadable.
        pop       = (count != '0) & (~instr_valid | instr_ready);
        head      = mem[rd_ptr];
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= {data_a, data_b};
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wrreg_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wrfull  <= 1'b0;
        end else begin
            wrreg_q <= wrreg;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count  <= count_nxt;
            wrfull <= (count_nxt == FULL_CNT);
        end
    end

    // Output stage: NOP entries (opcode 0) are consumed here but never presented.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            instr_valid <= 1'b0;
            instr_a     <= '0;
            instr_b     <= '0;
        end else if (pop) begin
            instr_a     <= head[63:32];
            instr_b     <= head[31:0];
            instr_valid <= (head[35:32] != 4'h0);
        end else if (instr_valid & instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

    assign instr_opcode = instr_a[3:0];

    // Frame divider: the processor's clear edge takes priority over a coincident frame_end.
    assign rpc_rise = reset_pulsecounter & ~rpc_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rpc_q     <= 1'b0;
            frame_cnt <= '0;
            screen    <= 1'b0;
        end else begin
            rpc_q <= reset_pulsecounter;
            if (rpc_rise) begin
                frame_cnt <= '0;
                screen    <= 1'b0;
            end else if (frame_end) begin
                if (frame_cnt + 8'd1 == DIV) begin
                    frame_cnt <= '0;
                    screen    <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_instruction_buffer.sv
// Directed bench for gpu_instruction_buffer (DEPTH_LOG2=4, FRAME_DIV=3).
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_gpu_instruction_buffer;

    int n_checks = 0;
    int n_fail   = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrreg;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        wrfull;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_opcode;
    logic [31:0] instr_a;
    logic [31:0] instr_b;
    logic        frame_end;
    logic        reset_pulsecounter;
    logic        screen;

    always #5 clk = ~clk;

    gpu_instruction_buffer #(
        .DEPTH_LOG2(4),
        .FRAME_DIV (3)
    ) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .wrreg             (wrreg),
        .data_a            (data_a),
        .data_b            (data_b),
        .wrfull            (wrfull),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr_opcode      (instr_opcode),
        .instr_a           (instr_a),
        .instr_b           (instr_b),
        .frame_end         (frame_end),
        .reset_pulsecounter(reset_pulsecounter),
        .screen            (screen)
    );

    // Monitor state used while checking the NOP filter.
    bit         mon_en = 1'b0;
    bit         nop_valid_seen = 1'b0;
    logic [3:0] seen_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en && instr_valid) begin
            if (instr_opcode == 4'h0) nop_valid_seen = 1'b1;
            seen_q.push_back(instr_opcode);
        end
    endtask

    // One write: strobe high for one edge, low for one edge.
    task automatic strobe(input logic [31:0] a, input logic [31:0] b);
        data_a = a;
        data_b = b;
        wrreg  = 1'b1;
        tick();
        wrreg  = 1'b0;
        tick();
    endtask

    task automatic frame_pulse();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
    endtask

    initial begin
        logic        stable;
        logic        stale;
        logic [3:0]  ops [4];
        logic [31:0] exp_a;
        logic [31:0] exp_b;

        rst_n              = 1'b0;
        wrreg              = 1'b0;
        data_a             = '0;
        data_b             = '0;
        instr_ready        = 1'b0;
        frame_end          = 1'b0;
        reset_pulsecounter = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        chk("rst_wrfull",  64'(wrfull),       64'd0);
        chk("rst_valid",   64'(instr_valid),  64'd0);
        chk("rst_opcode",  64'(instr_opcode), 64'd0);
        chk("rst_a",       64'(instr_a),      64'd0);
        chk("rst_b",       64'(instr_b),      64'd0);
        chk("rst_screen",  64'(screen),       64'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- single write, held strobe, stall stability
        data_a = 32'h0000_0012;
        data_b = 32'hDEAD_BEEF;
        wrreg  = 1'b1;
        tick();
        chk("single_valid_k", 64'(instr_valid), 64'd0);
        tick();
        chk("single_valid_k1", 64'(instr_valid), 64'd1);
        chk("single_opcode",   64'(instr_opcode), 64'd2);
        chk("single_ab",       {instr_a, instr_b}, 64'h0000_0012_DEAD_BEEF);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) wrreg = 1'b0;
            tick();
            if (!instr_valid || instr_a !== 32'h0000_0012 || instr_b !== 32'hDEAD_BEEF)
                stable = 1'b0;
        end
        chk("stall_stable", 64'(stable), 64'd1);
        chk("single_one_entry", 64'(dut.count), 64'd0);
        instr_ready = 1'b1;
        tick();
        chk("single_xfer", 64'(instr_valid), 64'd0);
        tick();
        tick();
        chk("single_no_dup", 64'(instr_valid), 64'd0);
        instr_ready = 1'b0;

        // ---------------- fill and overflow
        for (int i = 0; i < 17; i++) begin
            strobe((32'(i) << 4) | 32'h1, 32'hB000_0000 | 32'(i));
            if (i == 15) chk("fill_not_full_15", 64'(wrfull), 64'd0);
        end
        chk("fill_wrfull", 64'(wrfull), 64'd1);
        chk("fill_stage",  64'(instr_a), 64'h0000_0001);
        strobe(32'h0000_0FF1, 32'hFFFF_FFFF);
        chk("overflow_wrfull", 64'(wrfull),    64'd1);
        chk("overflow_count",  64'(dut.count), 64'd16);
        instr_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            exp_a = (32'(j) << 4) | 32'h1;
            exp_b = 32'hB000_0000 | 32'(j);
            chk("drain_valid", 64'(instr_valid), 64'd1);
            chk("drain_ab", {instr_a, instr_b}, {exp_a, exp_b});
            if (j == 1) chk("drain_wrfull_clear", 64'(wrfull), 64'd0);
            tick();
        end
        chk("drain_empty", 64'(instr_valid), 64'd0);
        tick();
        chk("drain_no_dropped", 64'(instr_valid), 64'd0);

        // ---------------- NOP filter
        ops = '{4'h1, 4'h0, 4'h0, 4'h3};
        seen_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe(32'h0000_0100 | 32'(ops[i]), 32'hC000_0000 | 32'(i));
        end
        repeat (6) tick();
        mon_en = 1'b0;
        chk("nop_count",    64'(seen_q.size()), 64'd2);
        if (seen_q.size() == 2) begin
            chk("nop_first",  64'(seen_q[0]), 64'd1);
            chk("nop_second", 64'(seen_q[1]), 64'd3);
        end
        chk("nop_never_valid", 64'(nop_valid_seen), 64'd0);
        instr_ready = 1'b0;

        // ---------------- frame tick
        frame_pulse();
        frame_pulse();
        chk("frame_two", 64'(screen), 64'd0);
        frame_end = 1'b1;
        tick();
        chk("frame_third", 64'(screen), 64'd1);
        frame_end = 1'b0;
        tick();
        frame_pulse();
        chk("frame_sticky", 64'(screen), 64'd1);
        reset_pulsecounter = 1'b1;
        frame_end          = 1'b1;
        tick();
        chk("frame_clear_screen", 64'(screen),        64'd0);
        chk("frame_clear_cnt",    64'(dut.frame_cnt), 64'd0);
        frame_end = 1'b0;
        tick();
        reset_pulsecounter = 1'b0;
        tick();
        frame_pulse();
        frame_pulse();
        chk("frame_recount_two", 64'(screen), 64'd0);
        frame_pulse();
        chk("frame_recount_three", 64'(screen), 64'd1);

        // ---------------- async reset with queued entries
        for (int i = 0; i < 6; i++) begin
            strobe(32'h0000_00A5 | (32'(i) << 8), 32'hD000_0000 | 32'(i));
        end
        chk("pre_rst_valid", 64'(instr_valid), 64'd1);
        chk("pre_rst_count", 64'(dut.count),   64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  64'(instr_valid),  64'd0);
        chk("arst_ab",     {instr_a, instr_b}, 64'd0);
        chk("arst_opcode", 64'(instr_opcode), 64'd0);
        chk("arst_wrfull", 64'(wrfull),       64'd0);
        chk("arst_screen", 64'(screen),       64'd0);
        tick();
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (instr_valid !== 1'b0) stale = 1'b1;
        end
        chk("post_rst_no_stale", 64'(stale), 64'd0);
        strobe(32'h0000_0077, 32'h0000_1234);
        chk("post_rst_valid", 64'(instr_valid), 64'd1);
        chk("post_rst_ab", {instr_a, instr_b}, 64'h0000_0077_0000_1234);
        tick();
        chk("post_rst_xfer", 64'(instr_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
